miriscv_lsu: RTL and testbench

- Load-store unit in the miriscv execute/memory stage, directly downstream of the ALU.
- Takes the ALU-computed effective address plus store data and access size, and runs one data-memory transaction over a req/gnt/rvalid interface.
- Generates byte enables and lane-replicated write data; extracts, sign- or zero-extends, and returns load data.
- Stalls the pipeline while a transaction is outstanding.

---
 rtl/miriscv_lsu.sv | 136 +++++++++++++
 tb/tb_miriscv_lsu.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_lsu.sv
// miriscv_lsu: single-transaction load-store unit.
// Drives a req/gnt/rvalid data port; extends load data.
module miriscv_lsu #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_size_i,
  input  logic [XLEN-1:0]   lsu_addr_i,
  input  logic [XLEN-1:0]   lsu_wdata_i,
  output logic [XLEN-1:0]   lsu_rdata_o,
  output logic              lsu_done_o,
  output logic              lsu_stall_o,
  output logic              lsu_misalign_o,
  output logic              data_req_o,
  output logic              data_we_o,
  output logic [XLEN/8-1:0] data_be_o,
  output logic [XLEN-1:0]   data_addr_o,
  output logic [XLEN-1:0]   data_wdata_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [XLEN-1:0]   data_rdata_i
);

  localparam int NB = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic [2:0]      size_q;
  logic            we_q;

  logic            mis;
  logic            idle;
  logic            go;
  logic            in_req;
  logic [1:0]      off;
  logic [NB-1:0]   be;
  logic [XLEN-1:0] wd;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] ld;

  always_comb begin
    unique case (1'b1)
      lsu_size_i[1:0] == 2'b00: mis = 1'b0;
      lsu_size_i[1:0] == 2'b01: mis = lsu_addr_i[0];
      default:                  mis = |lsu_addr_i[1:0];
    endcase
  end

  // outputs are forced low while reset is held
  assign idle   = arstn_i & (state_q == IDLE);
  assign go     = idle & lsu_req_i & ~mis;
  assign in_req = (state_q == REQ);
  assign off    = addr_q[1:0];
  assign sh     = data_rdata_i >> {off, 3'b000};

  always_comb begin
    unique case (1'b1)
      size_q[1:0] == 2'b00: begin
        be = NB'(1) << off;
        wd = {NB{wdata_q[7:0]}};
        ld = size_q[2] ? {{(XLEN-8){1'b0}}, sh[7:0]}
                       : {{(XLEN-8){sh[7]}}, sh[7:0]};
      end
      size_q[1:0] == 2'b01: begin
        be = NB'(3) << off;
        wd = {(NB/2){wdata_q[15:0]}};
        ld = size_q[2] ? {{(XLEN-16){1'b0}}, sh[15:0]}
                       : {{(XLEN-16){sh[15]}}, sh[15:0]};
      end
      default: begin
        be = '1;
        wd = wdata_q;
        ld = sh;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go) begin
            addr_q  <= lsu_addr_i;
            wdata_q <= lsu_wdata_i;
            size_q  <= lsu_size_i;
            we_q    <= lsu_we_i;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (data_gnt_i) state_q <= RESP;
        end
        RESP: begin
          if (data_rvalid_i) begin
            rdata_q <= we_q ? '0 : ld;
            state_q <= DONE;
          end
        end
        default: begin
          rdata_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign lsu_rdata_o    = rdata_q;
  assign lsu_done_o     = (state_q == DONE);
  assign lsu_stall_o    = go | in_req | (state_q == RESP);
  assign lsu_misalign_o = idle & lsu_req_i & mis;
  assign data_req_o     = in_req;
  assign data_we_o      = in_req & we_q;
  assign data_be_o      = in_req ? be : '0;
  assign data_addr_o    = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign data_wdata_o   = in_req ? wd : '0;

endmodule

// File: tb/tb_miriscv_lsu.sv
// tb_miriscv_lsu: randomized and directed checks of miriscv_lsu
// against a byte-level reference model.
module tb_miriscv_lsu;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic [31:0] lsu_rdata_o;
  logic        lsu_done_o;
  logic        lsu_stall_o;
  logic        lsu_misalign_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  int checks = 0;
  int failures = 0;

  miriscv_lsu #(.XLEN(32)) dut (
    .clk_i          (clk_i),
    .arstn_i        (arstn_i),
    .lsu_req_i      (lsu_req_i),
    .lsu_we_i       (lsu_we_i),
    .lsu_size_i     (lsu_size_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_rdata_o    (lsu_rdata_o),
    .lsu_done_o     (lsu_done_o),
    .lsu_stall_o    (lsu_stall_o),
    .lsu_misalign_o (lsu_misalign_o),
    .data_req_o     (data_req_o),
    .data_we_o      (data_we_o),
    .data_be_o      (data_be_o),
    .data_addr_o    (data_addr_o),
    .data_wdata_o   (data_wdata_o),
    .data_gnt_i     (data_gnt_i),
    .data_rvalid_i  (data_rvalid_i),
    .data_rdata_i   (data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic int nbytes(logic [2:0] sz);
    if (sz[1:0] == 2'b00) return 1;
    if (sz[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] exp_be(logic [2:0] sz,
                                        logic [31:0] a);
    logic [3:0] m = '0;
    int n = nbytes(sz);
    int o = int'(a[1:0]);
    for (int i = 0; i < n; i++) m[o+i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] exp_wd(logic [2:0] sz,
                                         logic [31:0] d);
    logic [31:0] r;
    int n = nbytes(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i%n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_ld(logic [2:0] sz,
                                         logic [31:0] a,
                                         logic [31:0] w);
    int n = nbytes(sz);
    int o = int'(a[1:0]);
    longint v = 0;
    for (int i = 0; i < n; i++)
      v += longint'(w[8*(o+i) +: 8]) << (8*i);
    if (n < 4 && !sz[2] && v >= (longint'(1) << (8*n-1)))
      v -= longint'(1) << (8*n);
    return v[31:0];
  endfunction

  task automatic run_op(input logic we, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rw, input int gd,
                        input int rd, input bit chain);
    logic [3:0]  eb;
    logic [31:0] ew, er, ea;
    eb = exp_be(sz, a);
    ew = exp_wd(sz, wd);
    er = we ? 32'h0 : exp_ld(sz, a, rw);
    ea = {a[31:2], 2'b00};
    @(negedge clk_i);
    lsu_req_i = 1'b1;
    lsu_we_i = we;
    lsu_size_i = sz;
    lsu_addr_i = a;
    lsu_wdata_i = wd;
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b0;
    #1;
    checks++;
    if (lsu_stall_o !== 1'b1 || lsu_misalign_o !== 1'b0 ||
        data_req_o !== 1'b0 || lsu_done_o !== 1'b0 ||
        lsu_rdata_o !== 32'h0) begin
      failures++;
      $display("FAIL accept a=%h stall=%b mis=%b req=%b done=%b rd=%h want 1 0 0 0 0",
               a, lsu_stall_o, lsu_misalign_o, data_req_o,
               lsu_done_o, lsu_rdata_o);
    end
    for (int i = 0; i <= gd; i++) begin
      @(negedge clk_i);
      data_gnt_i = (i == gd);
      data_rvalid_i = 1'($urandom_range(0, 1));
      data_rdata_i = $urandom;
      #1;
      checks++;
      if (data_req_o !== 1'b1 || data_we_o !== we ||
          data_be_o !== eb || data_addr_o !== ea ||
          lsu_stall_o !== 1'b1 || lsu_done_o !== 1'b0) begin
        failures++;
        $display("FAIL req_phase c=%0d req=%b we=%b be=%b addr=%h stall=%b done=%b want 1 %b %b %h 1 0",
                 i, data_req_o, data_we_o, data_be_o, data_addr_o,
                 lsu_stall_o, lsu_done_o, we, eb, ea);
      end
      if (we) begin
        checks++;
        if (data_wdata_o !== ew) begin
          failures++;
          $display("FAIL wdata got=%h want=%h", data_wdata_o, ew);
        end
      end
    end
    for (int i = 0; i <= rd; i++) begin
      @(negedge clk_i);
      data_gnt_i = 1'($urandom_range(0, 1));
      data_rvalid_i = (i == rd);
      data_rdata_i = (i == rd) ? rw : $urandom;
      #1;
      checks++;
      if (data_req_o !== 1'b0 || lsu_stall_o !== 1'b1 ||
          lsu_done_o !== 1'b0) begin
        failures++;
        $display("FAIL resp_phase c=%0d req=%b stall=%b done=%b want 0 1 0",
                 i, data_req_o, lsu_stall_o, lsu_done_o);
      end
    end
    @(negedge clk_i);
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i = $urandom;
    #1;
    checks++;
    if (lsu_done_o !== 1'b1 || lsu_stall_o !== 1'b0 ||
        data_req_o !== 1'b0 || lsu_rdata_o !== er) begin
      failures++;
      $display("FAIL done sz=%b a=%h done=%b stall=%b req=%b rdata=%h want 1 0 0 %h",
               sz, a, lsu_done_o, lsu_stall_o, data_req_o,
               lsu_rdata_o, er);
    end
    if (!chain) begin
      @(negedge clk_i);
      lsu_req_i = 1'b0;
      #1;
      checks++;
      if (lsu_done_o !== 1'b0 || lsu_rdata_o !== 32'h0 ||
          lsu_stall_o !== 1'b0 || data_req_o !== 1'b0) begin
        failures++;
        $display("FAIL post_done done=%b rdata=%h stall=%b req=%b want 0 0 0 0",
                 lsu_done_o, lsu_rdata_o, lsu_stall_o, data_req_o);
      end
    end
  endtask

  task automatic test_reset;
    arstn_i = 1'b0;
    lsu_req_i = 1'b1;
    lsu_we_i = 1'b0;
    lsu_size_i = 3'b010;
    lsu_addr_i = 32'h1000_0000;
    lsu_wdata_i = 32'h0;
    data_gnt_i = 1'b1;
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if (lsu_rdata_o !== 0 || lsu_done_o !== 0 || lsu_stall_o !== 0 ||
        lsu_misalign_o !== 0 || data_req_o !== 0 || data_we_o !== 0 ||
        data_be_o !== 0 || data_addr_o !== 0 || data_wdata_o !== 0) begin
      failures++;
      $display("FAIL reset_state rd=%h done=%b stall=%b mis=%b req=%b be=%b addr=%h want all 0",
               lsu_rdata_o, lsu_done_o, lsu_stall_o, lsu_misalign_o,
               data_req_o, data_be_o, data_addr_o);
    end
    @(negedge clk_i);
    lsu_req_i = 1'b0;
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b0;
    arstn_i = 1'b1;
  endtask

  task automatic test_lw_latency;
    run_op(1'b0, 3'b010, 32'h1000_0008, 32'h0, $urandom, 0, 0, 1'b0);
  endtask

  task automatic test_load_ext;
    run_op(1'b0, 3'b000, 32'h2000_0003, 32'h0, 32'h80FF_1234, 0, 0, 1'b0);
    run_op(1'b0, 3'b100, 32'h2000_0003, 32'h0, 32'h80FF_1234, 0, 0, 1'b0);
    run_op(1'b0, 3'b101, 32'h2000_0002, 32'h0, 32'h80FF_1234, 0, 0, 1'b0);
    run_op(1'b0, 3'b001, 32'h2000_0002, 32'h0, 32'h80FF_1234, 0, 1, 1'b0);
  endtask

  task automatic test_store;
    run_op(1'b1, 3'b000, 32'h3000_0001, 32'h0000_00A5, $urandom, 0, 0, 1'b0);
    run_op(1'b1, 3'b001, 32'h3000_0002, 32'h0000_BEEF, $urandom, 0, 0, 1'b0);
    run_op(1'b1, 3'b010, 32'h3000_0004, 32'hCAFE_F00D, $urandom, 0, 2, 1'b0);
  endtask

  task automatic test_gnt_wait;
    run_op(1'b0, 3'b010, 32'h4000_0010, 32'h0, $urandom, 5, 0, 1'b0);
    run_op(1'b1, 3'b000, 32'h4000_0013, 32'h0000_005A, $urandom, 5, 0, 1'b0);
  endtask

  task automatic test_undef_size;
    run_op(1'b0, 3'b011, 32'h5000_0000, 32'h0, 32'h8123_4567, 0, 0, 1'b0);
    run_op(1'b0, 3'b110, 32'h5000_0004, 32'h0, 32'hF000_000F, 0, 0, 1'b0);
    run_op(1'b1, 3'b111, 32'h5000_0008, 32'h1234_5678, $urandom, 0, 0, 1'b0);
  endtask

  task automatic test_misalign;
    logic [2:0]  szs [5] = '{3'b010, 3'b010, 3'b010, 3'b001, 3'b101};
    logic [31:0] ads [5] = '{32'h6000_0002, 32'h6000_0001,
                             32'h6000_0003, 32'h6000_0001,
                             32'h6000_0003};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      lsu_req_i = 1'b1;
      lsu_we_i = k[0];
      lsu_size_i = szs[k];
      lsu_addr_i = ads[k];
      #1;
      checks++;
      if (lsu_misalign_o !== 1'b1 || lsu_stall_o !== 1'b0 ||
          data_req_o !== 1'b0) begin
        failures++;
        $display("FAIL misalign k=%0d mis=%b stall=%b req=%b want 1 0 0",
                 k, lsu_misalign_o, lsu_stall_o, data_req_o);
      end
      @(negedge clk_i);
      #1;
      checks++;
      if (data_req_o !== 1'b0 || lsu_misalign_o !== 1'b1 ||
          lsu_stall_o !== 1'b0) begin
        failures++;
        $display("FAIL misalign_hold k=%0d req=%b mis=%b stall=%b want 0 1 0",
                 k, data_req_o, lsu_misalign_o, lsu_stall_o);
      end
      lsu_req_i = 1'b0;
      #1;
      checks++;
      if (lsu_misalign_o !== 1'b0) begin
        failures++;
        $display("FAIL misalign_clear k=%0d mis=%b want 0",
                 k, lsu_misalign_o);
      end
    end
  endtask

  task automatic test_back_to_back;
    run_op(1'b0, 3'b010, 32'h7000_0000, 32'h0, $urandom, 0, 0, 1'b1);
    run_op(1'b1, 3'b001, 32'h7000_0006, $urandom, $urandom, 0, 0, 1'b1);
    run_op(1'b0, 3'b000, 32'h7000_0009, 32'h0, $urandom, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid;
    @(negedge clk_i);
    lsu_req_i = 1'b1;
    lsu_we_i = 1'b0;
    lsu_size_i = 3'b010;
    lsu_addr_i = 32'h8000_0000;
    @(negedge clk_i);
    data_gnt_i = 1'b1;
    @(negedge clk_i);
    data_gnt_i = 1'b0;
    arstn_i = 1'b0;
    #1;
    checks++;
    if (lsu_rdata_o !== 0 || lsu_done_o !== 0 || lsu_stall_o !== 0 ||
        lsu_misalign_o !== 0 || data_req_o !== 0 || data_we_o !== 0 ||
        data_be_o !== 0 || data_addr_o !== 0 || data_wdata_o !== 0) begin
      failures++;
      $display("FAIL reset_mid done=%b stall=%b req=%b be=%b addr=%h want all 0",
               lsu_done_o, lsu_stall_o, data_req_o, data_be_o,
               data_addr_o);
    end
    @(negedge clk_i);
    arstn_i = 1'b1;
    lsu_req_i = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    #1;
    checks++;
    if (lsu_done_o !== 0 || lsu_stall_o !== 0 || data_req_o !== 0 ||
        lsu_rdata_o !== 0) begin
      failures++;
      $display("FAIL stray_rvalid done=%b stall=%b req=%b rd=%h want 0 0 0 0",
               lsu_done_o, lsu_stall_o, data_req_o, lsu_rdata_o);
    end
    run_op(1'b0, 3'b010, 32'h8000_0004, 32'h0, $urandom, 0, 0, 1'b0);
  endtask

  task automatic test_random;
    logic [2:0]  szs [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  sz;
    logic [31:0] a;
    for (int k = 0; k < 40; k++) begin
      sz = szs[$urandom_range(0, 4)];
      a = $urandom;
      if (nbytes(sz) == 4) a[1:0] = 2'b00;
      if (nbytes(sz) == 2) a[0] = 1'b0;
      run_op(1'($urandom_range(0, 1)), sz, a, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3),
             (k < 39) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_lw_latency();
    test_load_ext();
    test_store();
    test_gnt_wait();
    test_undef_size();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
